// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter sharing the register-file write port among NREQ requesters.
// Define WB_FORWARD_EN to add combinational forwarding of the staged write to two read selects.
module rf_write_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int CW   = 16,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_wsel,
    input  logic [NREQ*DW-1:0]   req_wdat,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 halt,
    output logic                 rf_WEN,
    output logic [AW-1:0]        rf_wsel,
    output logic [DW-1:0]        rf_wdat,
    output logic [IW-1:0]        grant_id,
    output logic [CW-1:0]        conflict_cnt
`ifdef WB_FORWARD_EN
    ,
    input  logic [AW-1:0]        rsel1,
    input  logic [AW-1:0]        rsel2,
    output logic                 fwd1_hit,
    output logic                 fwd2_hit,
    output logic [DW-1:0]        fwd1_dat,
    output logic [DW-1:0]        fwd2_dat
`endif
);
    logic [IW-1:0] ptr_q, ptr_d, gid_q, gnt_idx;
    logic          gnt_any, gnt, wen_q, wen_d, busy;
    logic [AW-1:0] wsel_q, win_wsel;
    logic [DW-1:0] wdat_q, win_wdat;
    logic [CW-1:0] cnt_q, cnt_d;

    // Scan farthest-first so the nearest valid index from ptr_q wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr_q) + k) % NREQ]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign gnt       = gnt_any && !halt && nRST;
    assign req_ready = gnt ? (NREQ'(1) << gnt_idx) : '0;
    assign win_wsel  = req_wsel[int'(gnt_idx)*AW +: AW];
    assign win_wdat  = req_wdat[int'(gnt_idx)*DW +: DW];
    // r0 is hard-wired to zero, so such writes complete the handshake but never reach the rf.
    assign wen_d     = gnt && (win_wsel != '0);
    assign ptr_d     = gnt ? ((gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1) : ptr_q;
    assign busy      = !halt && ($countones(req_valid) > 1);
    assign cnt_d     = (busy && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wen_q  <= 1'b0;
            wsel_q <= '0;
            wdat_q <= '0;
            gid_q  <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            wen_q <= wen_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (gnt) begin
                wsel_q <= win_wsel;
                wdat_q <= win_wdat;
                gid_q  <= gnt_idx;
            end
        end
    end

    assign rf_WEN       = wen_q;
    assign rf_wsel      = wsel_q;
    assign rf_wdat      = wdat_q;
    assign grant_id     = gid_q;
    assign conflict_cnt = cnt_q;

`ifdef WB_FORWARD_EN
    assign fwd1_hit = wen_q && (wsel_q == rsel1) && (rsel1 != '0);
    assign fwd2_hit = wen_q && (wsel_q == rsel2) && (rsel2 != '0);
    assign fwd1_dat = fwd1_hit ? wdat_q : '0;
    assign fwd2_dat = fwd2_hit ? wdat_q : '0;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: randomized scoreboard bench for rf_write_arbiter against a round-robin model.
module tb_rf_write_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int CW   = 8;
    localparam int IW   = 1;
    localparam int CMAX = (1 << CW) - 1;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*AW-1:0] req_wsel = '0;
    logic [NREQ*DW-1:0] req_wdat = '0;
    logic [NREQ-1:0]   req_ready;
    logic              halt = 1'b0;
    logic              rf_WEN;
    logic [AW-1:0]     rf_wsel;
    logic [DW-1:0]     rf_wdat;
    logic [IW-1:0]     grant_id;
    logic [CW-1:0]     conflict_cnt;
`ifdef WB_FORWARD_EN
    logic [AW-1:0]     rsel1 = '0, rsel2 = '0;
    logic              fwd1_hit, fwd2_hit;
    logic [DW-1:0]     fwd1_dat, fwd2_dat;
`endif

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
        .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_wsel(req_wsel), .req_wdat(req_wdat),
        .req_ready(req_ready), .halt(halt), .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
        .grant_id(grant_id), .conflict_cnt(conflict_cnt)
`ifdef WB_FORWARD_EN
        , .rsel1(rsel1), .rsel2(rsel2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_dat(fwd1_dat), .fwd2_dat(fwd2_dat)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] wsel;
        logic [DW-1:0] wdat;
        int            gid;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    int errors = 0;
    int checks = 0;
    int m_ptr = 0, m_cnt = 0, m_gid = 0;
    bit m_wen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every write the model stages must appear on the rf port, in order, and nothing else.
    always @(negedge CLK) begin
        if (nRST && rf_WEN === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got wsel=%0d wdat=%0h expected none", rf_wsel, rf_wdat);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rf_wsel", 64'(rf_wsel), 64'(mon_e.wsel));
                chk("rf_wdat", 64'(rf_wdat), 64'(mon_e.wdat));
                chk("wr_grant_id", 64'(grant_id), 64'(mon_e.gid));
            end
        end
    end

    task automatic do_reset();
        nRST = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("rst_rf_WEN", 64'(rf_WEN), 0);
        chk("rst_rf_wsel", 64'(rf_wsel), 0);
        chk("rst_rf_wdat", 64'(rf_wdat), 0);
        chk("rst_grant_id", 64'(grant_id), 0);
        chk("rst_conflict_cnt", 64'(conflict_cnt), 0);
        chk("rst_req_ready", 64'(req_ready), 0);
        exp_q.delete();
        m_ptr = 0; m_cnt = 0; m_gid = 0; m_wen = 0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    // Called just after a rising edge; drives one cycle and checks against the model.
    task automatic step(input logic [1:0] v, input logic h, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int w;
        logic [AW-1:0] ws;
        req_valid = v;
        halt = h;
        req_wsel = {s1, s0};
        req_wdat = {d1, d0};
        #1;
        w = -1;
        if (!h)
            for (int k = 0; k < NREQ; k++) begin
                int j = (m_ptr + k) % NREQ;
                if (w < 0 && v[j]) w = j;
            end
        chk("req_ready", 64'(req_ready), (w < 0) ? 64'd0 : 64'(1 << w));
        if (!h && $countones(v) >= 2 && m_cnt < CMAX) m_cnt++;
        m_wen = 0;
        if (w >= 0) begin
            ws = (w == 0) ? s0 : s1;
            m_gid = w;
            m_ptr = (w + 1) % NREQ;
            if (ws != 0) begin
                m_wen = 1;
                exp_q.push_back('{wsel: ws, wdat: (w == 0) ? d0 : d1, gid: w});
            end
        end
        @(posedge CLK);
        #1;
        chk("rf_WEN", 64'(rf_WEN), 64'(m_wen));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
        chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    endtask

    initial begin
        do_reset();
        step(2'b01, 0, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0);
        chk("single_wen", 64'(rf_WEN), 1);
        chk("single_wdat", 64'(rf_wdat), 64'hDEADBEEF);
        for (int n = 0; n < 6; n++)
            step(2'b11, 0, AW'(n + 1), AW'(n + 9), DW'(n), DW'(n + 100));
        chk("cnt_after_6", 64'(conflict_cnt), 6);
        for (int n = 0; n < CMAX; n++)
            step(2'b11, 0, AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), $urandom, $urandom);
        chk("cnt_saturated", 64'(conflict_cnt), CMAX);
        step(2'b10, 0, 5'd4, 5'd0, 32'h1, 32'h55);
        chk("r0_drop_wen", 64'(rf_WEN), 0);
        step(2'b11, 0, 5'd6, 5'd7, 32'hA0, 32'hA1);
        chk("rr_after_r0", 64'(grant_id), 0);
        step(2'b01, 0, 5'd7, 5'd0, 32'hAA, 32'h0);
        for (int n = 0; n < 3; n++)
            step(2'b11, 1, 5'd8, 5'd9, 32'hB0, 32'hB1);
        step(2'b11, 0, 5'd10, 5'd11, 32'hC0, 32'hC1);
        chk("halt_release_gid", 64'(grant_id), 1);
`ifdef WB_FORWARD_EN
        step(2'b01, 0, 5'd5, 5'd0, 32'h1234, 32'h0);
        rsel1 = 5'd5;
        rsel2 = 5'd0;
        #1;
        chk("fwd1_hit", 64'(fwd1_hit), 1);
        chk("fwd1_dat", 64'(fwd1_dat), 64'h1234);
        chk("fwd2_hit", 64'(fwd2_hit), 0);
        step(2'b00, 0, 5'd0, 5'd0, 32'h0, 32'h0);
        chk("fwd1_hit_idle", 64'(fwd1_hit), 0);
`endif
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                step(2'b11, 0, 5'd12, 5'd13, 32'hD0, 32'hD1);
                do_reset();
            end
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                 AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), $urandom, $urandom);
        end
        step(2'b00, 0, 5'd0, 5'd0, 32'h0, 32'h0);
        step(2'b00, 0, 5'd0, 5'd0, 32'h0, 32'h0);
        @(negedge CLK);
        #1;
        chk("writes_drained", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
